// File: rtl/popcount_pkg.sv
// Shared constants and types for the popcount window accumulator.
package popcount_pkg;

    localparam int unsigned ONEHOT_W  = 5;
    localparam int unsigned CNT_VAL_W = 3;

    // One-hot population count: bit i set means the count is i.
    typedef logic [ONEHOT_W-1:0] onehot_t;

endpackage

// File: rtl/popcount_onehot_decode.sv
// One-hot count to binary value decoder.
// Build option: ONEHOT_CHECK_EN selects strict one-hot checking; otherwise
// a highest-bit-wins priority decode is used.
module popcount_onehot_decode
    import popcount_pkg::*;
(
    input  onehot_t              onehot,
    output logic [CNT_VAL_W-1:0] value,
    output logic                 legal
);

`ifdef ONEHOT_CHECK_EN
    // Strict decode: anything other than a single set bit is illegal and maps to 0.
    always_comb begin
        value = '0;
        legal = 1'b1;
        unique case (onehot)
            5'b00001: value = 3'd0;
            5'b00010: value = 3'd1;
            5'b00100: value = 3'd2;
            5'b01000: value = 3'd3;
            5'b10000: value = 3'd4;
            default: begin
                value = 3'd0;
                legal = 1'b0;
            end
        endcase
    end
`else
    // Priority decode: highest set bit wins, all-zero maps to 0, every code is accepted.
    always_comb begin
        value = '0;
        legal = 1'b1;
        if (onehot[4])      value = 3'd4;
        else if (onehot[3]) value = 3'd3;
        else if (onehot[2]) value = 3'd2;
        else if (onehot[1]) value = 3'd1;
        else                value = 3'd0;
    end
`endif

endmodule

// File: rtl/popcount_window_acc.sv
// Windowed accumulator for one-hot popcount samples. Sums WINDOW accepted
// samples and presents each total on a valid/ready output register while the
// next window keeps accumulating.
// Build option: ONEHOT_CHECK_EN enables the sticky illegal-code flag on err.
module popcount_window_acc
    import popcount_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned SUM_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  onehot_t          in_onehot,
    output logic             in_ready,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [SUM_W-1:0] sum_data,
    output logic             err
);

    localparam int unsigned CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SUM_W-1:0]     acc_q, acc_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [SUM_W-1:0]     sum_data_q, sum_data_d;
    logic                 err_q, err_d;

    logic [CNT_VAL_W-1:0] value;
    logic                 legal;
    logic                 cnt_last;
    logic                 accept;
    logic [SUM_W-1:0]     acc_sum;

    popcount_onehot_decode u_decode (
        .onehot (in_onehot),
        .value  (value),
        .legal  (legal)
    );

    // Ready and acceptance: only the window-closing sample stalls, and only
    // while the previous total is still waiting to be taken.
    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        in_ready = ena && !(cnt_last && sum_valid_q && !sum_ready);
        accept   = in_valid && in_ready;
        acc_sum  = acc_q + {{(SUM_W - CNT_VAL_W){1'b0}}, value};
    end

    // Next-state for the window counter, accumulator, output register and err.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_valid_d = sum_valid_q;
        sum_data_d  = sum_data_q;
        // In priority mode legal is constant 1, so err never sets.
        err_d       = err_q | (accept & ~legal);

        if (sum_valid_q && sum_ready) begin
            sum_valid_d = 1'b0;
        end

        if (accept) begin
            if (cnt_last) begin
                cnt_d       = '0;
                acc_d       = '0;
                // A closing window overrides a same-cycle handshake clear.
                sum_valid_d = 1'b1;
                sum_data_d  = acc_sum;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_sum;
            end
        end
    end

    // State registers with synchronous active-low reset; partial sums are discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_valid_q <= sum_valid_d;
            sum_data_q  <= sum_data_d;
            err_q       <= err_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_popcount_window_acc.sv
// Directed self-checking bench for popcount_window_acc (WINDOW=16, SUM_W=7).
module tb_popcount_window_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [4:0] in_onehot;
    logic       in_ready;
    logic       sum_valid;
    logic       sum_ready;
    logic [6:0] sum_data;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

`ifdef ONEHOT_CHECK_EN
    localparam bit CHECK_MODE = 1'b1;
`else
    localparam bit CHECK_MODE = 1'b0;
`endif

    always #5 clk = ~clk;

    popcount_window_acc #(
        .WINDOW (16),
        .SUM_W  (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_onehot (in_onehot),
        .in_ready  (in_ready),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_data  (sum_data),
        .err       (err)
    );

    // Drive one cycle of inputs on the falling edge; outputs settle 1 time unit later.
    task automatic cyc(input logic v, input logic [4:0] oh, input logic e, input logic sr);
        @(negedge clk);
        in_valid  = v;
        in_onehot = oh;
        ena       = e;
        sum_ready = sr;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_onehot = 5'b0; sum_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (sum_valid !== 1'b0 || sum_data !== 7'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got sv=%b data=%0d err=%b rdy=%b, want 0/0/0/0",
                     sum_valid, sum_data, err, in_ready);
        end
        rst_n = 1'b1;
        cyc(1'b0, 5'b0, 1'b1, 1'b0);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_basic_window();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 5'b00100, 1'b1, 1'b1);
            compared++;
            if (sum_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_early_valid: sample %0d got sum_valid=%b, want 0", i, sum_valid);
            end
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== 7'd32) begin
            mismatched++;
            $display("FAIL basic_total: got sv=%b data=%0d, want 1/32", sum_valid, sum_data);
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_pulse: got sum_valid=%b, want 0", sum_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 5'b10000, 1'b1, 1'b0);
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_win1_ready: sample %0d got in_ready=%b, want 1", i, in_ready);
            end
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 5'b10000, 1'b1, 1'b0);
            compared++;
            if (in_ready !== 1'b1 || sum_valid !== 1'b1 || sum_data !== 7'd64) begin
                mismatched++;
                $display("FAIL bp_win2: cnt %0d got rdy=%b sv=%b data=%0d, want 1/1/64",
                         i, in_ready, sum_valid, sum_data);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 5'b10000, 1'b1, 1'b0);
            compared++;
            if (in_ready !== 1'b0 || sum_data !== 7'd64) begin
                mismatched++;
                $display("FAIL bp_stall: got rdy=%b data=%0d, want 0/64", in_ready, sum_data);
            end
        end
        cyc(1'b1, 5'b10000, 1'b1, 1'b1);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== 7'd64 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_second_total: got sv=%b data=%0d rdy=%b, want 1/64/1",
                     sum_valid, sum_data, in_ready);
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_drain: got sum_valid=%b, want 0", sum_valid);
        end
    endtask

    task automatic test_ena_gap();
        for (int i = 0; i < 8; i++) cyc(1'b1, 5'b00010, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'b10000, 1'b0, 1'b1);
            compared++;
            if (in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL ena_low_ready: got in_ready=%b, want 0", in_ready);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 5'b00010, 1'b1, 1'b1);
            compared++;
            if (sum_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL ena_early_valid: sample %0d got sum_valid=%b, want 0", i, sum_valid);
            end
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b0);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== 7'd16) begin
            mismatched++;
            $display("FAIL ena_total: got sv=%b data=%0d, want 1/16", sum_valid, sum_data);
        end
    endtask

    // Enters with total 16 pending; the next window closes in the cycle it is taken.
    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 5'b01000, 1'b1, 1'b0);
            compared++;
            if (in_ready !== 1'b1 || sum_valid !== 1'b1 || sum_data !== 7'd16) begin
                mismatched++;
                $display("FAIL b2b_hold: cnt %0d got rdy=%b sv=%b data=%0d, want 1/1/16",
                         i, in_ready, sum_valid, sum_data);
            end
        end
        cyc(1'b1, 5'b01000, 1'b1, 1'b1);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready: got in_ready=%b, want 1", in_ready);
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b0);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== 7'd48) begin
            mismatched++;
            $display("FAIL b2b_total: got sv=%b data=%0d, want 1/48", sum_valid, sum_data);
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b0 || sum_data !== 7'd48) begin
            mismatched++;
            $display("FAIL b2b_drain: got sv=%b data=%0d, want 0/48", sum_valid, sum_data);
        end
    endtask

    task automatic test_illegal_code();
        logic [6:0] exp_total;
        exp_total = CHECK_MODE ? 7'd0 : 7'd2;
        cyc(1'b1, 5'b00110, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 5'b00001, 1'b1, 1'b1);
            compared++;
            if (err !== CHECK_MODE || sum_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL illegal_err: sample %0d got err=%b sv=%b, want %b/0",
                         i, err, sum_valid, CHECK_MODE);
            end
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== exp_total || err !== CHECK_MODE) begin
            mismatched++;
            $display("FAIL illegal_total: got sv=%b data=%0d err=%b, want 1/%0d/%b",
                     sum_valid, sum_data, err, exp_total, CHECK_MODE);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 5'b00010, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 5'b00010, 1'b1, 1'b0);
            compared++;
            if (sum_valid !== 1'b1 || sum_data !== 7'd16) begin
                mismatched++;
                $display("FAIL mrst_pending: cnt %0d got sv=%b data=%0d, want 1/16",
                         i, sum_valid, sum_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; ena = 1'b0;
        cyc(1'b0, 5'b0, 1'b0, 1'b0);
        compared++;
        if (sum_valid !== 1'b0 || sum_data !== 7'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mrst_outputs: got sv=%b data=%0d err=%b rdy=%b, want 0/0/0/0",
                     sum_valid, sum_data, err, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 5'b00010, 1'b1, 1'b1);
            compared++;
            if (sum_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL mrst_early_valid: sample %0d got sum_valid=%b, want 0", i, sum_valid);
            end
        end
        cyc(1'b0, 5'b0, 1'b1, 1'b1);
        compared++;
        if (sum_valid !== 1'b1 || sum_data !== 7'd16) begin
            mismatched++;
            $display("FAIL mrst_total: got sv=%b data=%0d, want 1/16", sum_valid, sum_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_backpressure();
        test_ena_gap();
        test_back_to_back();
        test_illegal_code();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
